seq_ite_reg_bank: RTL and testbench
===================================

// Module: seq_ite_reg_bank
// PURPOSE
//   Parametrised successor of the single 8-bit ite-fed register: DEPTH entries of WIDTH bits,
//   each updated via an opcode-selected next-state mux (hold/load/rotate/clear). A one-deep
//   registered read stage with valid/ready handshake drives O_a. sel forces O_a to zero.
//   Serves as a small sequential scratch bank between syntax-generated datapath stages.
// PARAMETERS
//   WIDTH  8  bits per entry and on wdata/O_a
//   DEPTH  4  number of entries, >=2; AW = max(1,$clog2(DEPTH))
//   INIT   0  reset/clear value of every entry (WIDTH bits)
// PORTS
//   CLK          in   1      clock, rising edge
//   ASYNCRESETN  in   1      asynchronous active-low reset
//   op           in   2      00 HOLD, 01 LOAD, 10 ROTATE, 11 CLEAR
//   addr         in   AW     LOAD target entry
//   wdata        in   WIDTH  LOAD data
//   rd_req       in   1      read request
//   rd_addr      in   AW     read entry index
//   rd_ack       out  1      read request accepted this cycle (combinational)
//   O_a          out  WIDTH  read data (zero while sel=1)
//   O_valid      out  1      O_a holds accepted read data
//   O_ready      in   1      downstream consumes O_a when O_valid=1
//   sel          in   1      1: O_a forced to 0; 0: O_a = output register
// BEHAVIOUR
//   Reset (ASYNCRESETN=0, immediate, no clock needed): all entries=INIT, out_reg=0,
//     O_valid=0. Release synchronous to CLK; the first edge after release acts normally.
//   Entry update, every rising edge, per op:
//     HOLD   : all entries keep their values.
//     LOAD   : entry[addr]<=wdata if addr<DEPTH; addr>=DEPTH means no write (silently dropped).
//     ROTATE : entry[i]<=entry[i-1] for i>=1, entry[0]<=entry[DEPTH-1] (wraps).
//     CLEAR  : all entries<=INIT.
//   Output stage FSM, two states:
//     EMPTY (O_valid=0) -> FULL on rd_ack.
//     FULL (O_valid=1): O_ready=1 & rd_ack -> FULL with new data (back-to-back);
//       O_ready=1 & !rd_req -> EMPTY; O_ready=0 -> hold.
//   rd_ack = rd_req & (!O_valid | O_ready); requests without ack are dropped, not queued.
//   Read latency 1 cycle: on the accepting edge, out_reg<=entry[rd_addr] pre-update value;
//     a same-edge LOAD/ROTATE/CLEAR is not visible. rd_addr>=DEPTH returns 0.
//   While O_valid=1 & O_ready=0, out_reg is stable regardless of op activity on the bank.
//   O_a = sel ? 0 : out_reg (combinational); sel has no effect on O_valid/rd_ack or state.
//   No arithmetic; all widths exact, no truncation or extension except the 0 fill.
// TESTING
//   1 Reset mid-operation: LOAD 8'hA5 @1, rd_req pending, drop ASYNCRESETN between edges
//     -> O_valid=0 and O_a=0 immediately; reading entry1 afterwards returns INIT=0.
//   2 LOAD 11,22,33,44 to entries 0..3, then read 2 with O_ready=1 -> O_a=33 one cycle
//     after ack; O_valid held for 1 cycle only.
//   3 ROTATE once, then read 0 -> 44; read 3 -> 33 (wrap check).
//   4 LOAD 8'h77 @1 and rd_req @1 on the same edge -> O_a=old value 11 (pre-update);
//     next read of 1 -> 77.
//   5 Back-pressure: O_ready=0 for 3 cycles with rd_req high -> rd_ack=0, O_a stable;
//     O_ready=1 with rd_req -> ack, new data on the next edge, no bubble.
//   6 sel=1 with O_valid=1 -> O_a=0, O_valid=1; CLEAR then read -> INIT; LOAD addr=DEPTH
//     (DEPTH=5 build) -> no entry changes.

Source files
------------

// File: rtl/seq_ite_reg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_ite_reg_bank                                              |
// | Brief    : DEPTH x WIDTH scratch register bank with opcode-driven update |
// |            (hold/load/rotate/clear) and a one-deep registered read stage |
// |            with valid/ready handshake. sel blanks the read data to zero. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seq_ite_reg_bank #(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '0,
  localparam int              AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_ack,
  output logic [WIDTH-1:0] O_a,
  output logic             O_valid,
  input  logic             O_ready,
  input  logic             sel
);

  localparam logic [1:0]  OP_HOLD   = 2'b00;
  localparam logic [1:0]  OP_LOAD   = 2'b01;
  localparam logic [1:0]  OP_ROTATE = 2'b10;
  localparam logic [1:0]  OP_CLEAR  = 2'b11;

  // Entry count at address width + 1 so the range test also works when DEPTH
  // is not a power of two (out-of-range addresses are representable).
  localparam logic [AW:0] C_DEPTH   = (AW + 1)'(DEPTH);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  state_t           state_q;
  state_t           state_d;

  logic             w_addr_ok;
  logic             w_rd_addr_ok;
  logic [WIDTH-1:0] w_rd_data;

  assign w_addr_ok    = ({1'b0, addr} < C_DEPTH);
  assign w_rd_addr_ok = ({1'b0, rd_addr} < C_DEPTH);

  // A request is taken when the output slot is free or being drained this cycle;
  // anything not taken is simply dropped.
  assign O_valid = (state_q == S_FULL);
  assign rd_ack  = rd_req & (~O_valid | O_ready);

  // Read source uses the bank contents before this edge's update.
  assign w_rd_data = w_rd_addr_ok ? mem_q[rd_addr] : '0;

  // Output blanking only touches the data path, never the handshake.
  assign O_a = sel ? '0 : out_q;

  // Next-state of the bank, selected by the opcode.
  always_comb begin
    mem_d = mem_q;
    case (op)
      OP_HOLD: begin
        mem_d = mem_q;
      end
      OP_LOAD: begin
        if (w_addr_ok) begin
          mem_d[addr] = wdata;
        end
      end
      OP_ROTATE: begin
        mem_d[0] = mem_q[DEPTH-1];
        for (int i = 1; i < DEPTH; i++) begin
          mem_d[i] = mem_q[i-1];
        end
      end
      OP_CLEAR: begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_d[i] = INIT;
        end
      end
      default: begin
        mem_d = mem_q;
      end
    endcase
  end

  // Output stage: capture on accept, drain to empty when consumed with no refill.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    if (rd_ack) begin
      state_d = S_FULL;
      out_d   = w_rd_data;
    end else if ((state_q == S_FULL) && O_ready) begin
      state_d = S_EMPTY;
    end
  end

  // Bank and output-stage registers with immediate reset.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= INIT;
      end
      out_q   <= '0;
      state_q <= S_EMPTY;
    end else begin
      mem_q   <= mem_d;
      out_q   <= out_d;
      state_q <= state_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_ite_reg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_ite_reg_bank                                           |
// | Brief    : Bench for seq_ite_reg_bank; one DEPTH=4 and one DEPTH=5 build |
// |            share the same stimulus and are compared to a simple model.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seq_ite_reg_bank;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             ASYNCRESETN = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [2:0]       addr = '0;
  logic [WIDTH-1:0] wdata = '0;
  logic             rd_req = 1'b0;
  logic [2:0]       rd_addr = '0;
  logic             O_ready = 1'b0;
  logic             sel = 1'b0;

  logic             rd_ack4, O_valid4, rd_ack5, O_valid5;
  logic [WIDTH-1:0] O_a4, O_a5;

  int passed = 0;
  int total  = 0;

  // Model state: index 0 = DEPTH 4 build, index 1 = DEPTH 5 build.
  int dep  [2] = '{4, 5};
  int init [2] = '{0, 'h3C};
  int ent  [2][8];
  int mval [2];
  int mout [2];

  always #5 CLK = ~CLK;

  seq_ite_reg_bank #(.WIDTH(WIDTH), .DEPTH(4), .INIT(8'h00)) u_dut4 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .op(op), .addr(addr[1:0]),
    .wdata(wdata), .rd_req(rd_req), .rd_addr(rd_addr[1:0]), .rd_ack(rd_ack4),
    .O_a(O_a4), .O_valid(O_valid4), .O_ready(O_ready), .sel(sel)
  );

  seq_ite_reg_bank #(.WIDTH(WIDTH), .DEPTH(5), .INIT(8'h3C)) u_dut5 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .op(op), .addr(addr),
    .wdata(wdata), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack5),
    .O_a(O_a5), .O_valid(O_valid5), .O_ready(O_ready), .sel(sel)
  );

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
  endtask

  function automatic int eff_addr(input int k, input int a);
    return (k == 0) ? (a % 4) : a;
  endfunction

  function automatic int model_ack(input int k);
    return (rd_req && (!mval[k] || O_ready)) ? 1 : 0;
  endfunction

  function automatic int model_oa(input int k);
    return sel ? 0 : mout[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) ent[k][i] = init[k];
      mval[k] = 0;
      mout[k] = 0;
    end
  endtask

  // One clock edge of the model, using the inputs as they stood before the edge.
  task automatic model_edge();
    int tmp [8];
    int ra, wa;
    for (int k = 0; k < 2; k++) begin
      ra = eff_addr(k, int'(rd_addr));
      wa = eff_addr(k, int'(addr));
      if (model_ack(k) != 0) begin
        mval[k] = 1;
        mout[k] = (ra < dep[k]) ? ent[k][ra] : 0;
      end else if (mval[k] != 0 && O_ready) begin
        mval[k] = 0;
      end
      case (op)
        2'b01: if (wa < dep[k]) ent[k][wa] = int'(wdata);
        2'b10: begin
          for (int i = 0; i < dep[k]; i++) tmp[i] = ent[k][i];
          for (int i = 0; i < dep[k]; i++) ent[k][(i + 1) % dep[k]] = tmp[i];
        end
        2'b11: for (int i = 0; i < dep[k]; i++) ent[k][i] = init[k];
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, 0, 32'(O_valid4), 32'(mval[0]));
    chk({tag, "_oa"},    0, 32'(O_a4),     32'(model_oa(0)));
    chk({tag, "_valid"}, 1, 32'(O_valid5), 32'(mval[1]));
    chk({tag, "_oa"},    1, 32'(O_a5),     32'(model_oa(1)));
  endtask

  // Called at posedge+1 with inputs set: check ack mid-cycle, clock, check outputs.
  task automatic cyc(input string tag);
    @(negedge CLK);
    chk({tag, "_ack"}, 0, 32'(rd_ack4), 32'(model_ack(0)));
    chk({tag, "_ack"}, 1, 32'(rd_ack5), 32'(model_ack(1)));
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic [1:0] o, input int a, input int wd,
                       input logic rq, input int ra, input logic rdy, input logic s);
    op      = o;
    addr    = 3'(a);
    wdata   = 8'(wd);
    rd_req  = rq;
    rd_addr = 3'(ra);
    O_ready = rdy;
    sel     = s;
  endtask

  initial begin
    model_reset();
    #1;
    check_outputs("reset");
    #1 ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;

    // Reset mid-operation
    drive(2'b01, 1, 'hA5, 1'b0, 0, 1'b1, 1'b0); cyc("t1_load");
    drive(2'b00, 0, 0,    1'b1, 1, 1'b1, 1'b0);
    #2 ASYNCRESETN = 1'b0;
    #1;
    model_reset();
    check_outputs("t1_async");
    ASYNCRESETN = 1'b1;
    cyc("t1_read1");
    chk("t1_init", 0, 32'(O_a4), 32'h00);
    chk("t1_init", 1, 32'(O_a5), 32'h3C);
    drive(2'b00, 0, 0, 1'b0, 0, 1'b1, 1'b0); cyc("t1_idle");

    // Fill and read back
    drive(2'b01, 0, 11, 1'b0, 0, 1'b1, 1'b0); cyc("t2_ld0");
    drive(2'b01, 1, 22, 1'b0, 0, 1'b1, 1'b0); cyc("t2_ld1");
    drive(2'b01, 2, 33, 1'b0, 0, 1'b1, 1'b0); cyc("t2_ld2");
    drive(2'b01, 3, 44, 1'b0, 0, 1'b1, 1'b0); cyc("t2_ld3");
    drive(2'b00, 0, 0,  1'b1, 2, 1'b1, 1'b0); cyc("t2_rd2");
    chk("t2_val33", 0, 32'(O_a4), 32'd33);
    drive(2'b00, 0, 0,  1'b0, 0, 1'b1, 1'b0); cyc("t2_drain");
    chk("t2_one_cycle", 0, 32'(O_valid4), 32'd0);

    // Rotate with wrap
    drive(2'b10, 0, 0, 1'b0, 0, 1'b1, 1'b0); cyc("t3_rot");
    drive(2'b00, 0, 0, 1'b1, 0, 1'b1, 1'b0); cyc("t3_rd0");
    chk("t3_wrap", 0, 32'(O_a4), 32'd44);
    drive(2'b00, 0, 0, 1'b1, 3, 1'b1, 1'b0); cyc("t3_rd3");
    chk("t3_rd3v", 0, 32'(O_a4), 32'd33);

    // Same-edge load and read sees pre-update value
    drive(2'b01, 1, 'h77, 1'b1, 1, 1'b1, 1'b0); cyc("t4_ldrd");
    chk("t4_old", 0, 32'(O_a4), 32'd11);
    drive(2'b00, 0, 0, 1'b1, 1, 1'b1, 1'b0); cyc("t4_rd1");
    chk("t4_new", 0, 32'(O_a4), 32'h77);

    // Back-pressure, then back-to-back accept
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 0, 0, 1'b1, 0, 1'b0, 1'b0); cyc("t5_stall");
      chk("t5_stable", 0, 32'(O_a4), 32'h77);
    end
    drive(2'b00, 0, 0, 1'b1, 2, 1'b1, 1'b0); cyc("t5_b2b");

    // sel blanking, clear, out-of-range load on the DEPTH 5 build
    drive(2'b00, 0, 0, 1'b0, 0, 1'b0, 1'b1); cyc("t6_sel");
    chk("t6_sel_oa", 0, 32'(O_a4), 32'd0);
    chk("t6_sel_v",  0, 32'(O_valid4), 32'd1);
    drive(2'b11, 0, 0, 1'b0, 0, 1'b1, 1'b0); cyc("t6_clr");
    drive(2'b00, 0, 0, 1'b1, 3, 1'b1, 1'b0); cyc("t6_rdclr");
    drive(2'b01, 5, 'hEE, 1'b0, 0, 1'b1, 1'b0); cyc("t6_ld5");
    for (int i = 0; i < 8; i++) begin
      drive(2'b00, 0, 0, 1'b1, i, 1'b1, 1'b0); cyc("t6_scan");
    end

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 7) == 0) drive(2'b00, 0, 0, rd_req, int'(rd_addr), O_ready, sel);
      cyc("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
